// File: rtl/apogee_dma_pkg.sv
// rtl/apogee_dma_pkg.sv - shared types, control bit positions and helpers for apogee_dma
package apogee_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_XFER,
    ST_DONE
  } dma_state_t;

  // Top two bits of a channel count register
  typedef enum logic [1:0] {
    XT_VERIFY     = 2'b00,
    XT_WRITE      = 2'b01,
    XT_READ       = 2'b10,
    XT_VERIFY_ALT = 2'b11
  } xfer_type_t;

  // Control register bit positions
  localparam int CTL_ROTATE   = 0;
  localparam int CTL_TC_STOP  = 1;
  localparam int CTL_AUTOLOAD = 2;
  localparam int CTL_BURST    = 3;
  localparam int CTL_BITS     = 4;

  // Strobe levels during XFER, packed as {ord_n, owe_n, oiord_n, oiowe_n}
  function automatic logic [3:0] strobe_pattern(input xfer_type_t xt);
    case (xt)
      XT_WRITE: strobe_pattern = 4'b1001;  // peripheral -> memory
      XT_READ:  strobe_pattern = 4'b0110;  // memory -> peripheral
      default:  strobe_pattern = 4'b1111;  // verify: address cycle only
    endcase
  endfunction

  // Replace the low or high byte of a 16-bit register image
  function automatic logic [15:0] merge_byte(input logic [15:0] cur, input logic hi,
                                             input logic [7:0] b);
    merge_byte = hi ? {b, cur[7:0]} : {cur[15:8], b};
  endfunction

endpackage

// File: rtl/apogee_dma_channel.sv
// rtl/apogee_dma_channel.sv - one channel: address/count registers, byte load, step, autoload port
module apogee_dma_channel
  import apogee_dma_pkg::*;
#(
  parameter int AW = 16,
  parameter int CW = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_addr,
  input  logic          wr_cnt,
  input  logic          byte_hi,
  input  logic [7:0]    wdata,
  input  logic          step,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [CW+1:0] load_cnt,
  output logic [AW-1:0] addr,
  output logic [CW+1:0] cnt,
  output logic          last
);

  localparam int CNTW = CW + 2;

  logic [AW-1:0]   addr_q;
  logic [CNTW-1:0] cnt_q;

  // CPU byte loads take precedence; an autoload replaces the post-transfer step
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (wr_addr) begin
      addr_q <= AW'(merge_byte(16'(addr_q), byte_hi, wdata));
    end else if (wr_cnt) begin
      cnt_q <= CNTW'(merge_byte(16'(cnt_q), byte_hi, wdata));
    end else if (load) begin
      addr_q <= load_addr;
      cnt_q  <= load_cnt;
    end else if (step) begin
      addr_q           <= addr_q + AW'(1);
      cnt_q[CW-1:0]    <= cnt_q[CW-1:0] - CW'(1);
    end
  end

  assign addr = addr_q;
  assign cnt  = cnt_q;
  // Count field at zero means the upcoming transfer is the final one
  assign last = (cnt_q[CW-1:0] == '0);

endmodule

// File: rtl/apogee_dma.sv
// rtl/apogee_dma.sv - multi-channel DMA controller with rotating priority, TC-stop, autoload and burst
// Reads: index 2*CHANNELS returns status (TC flags, bit7 update), 2*CHANNELS+1 returns the enable mask.
module apogee_dma
  import apogee_dma_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int AW       = 16,
  parameter int CW       = 14,
  parameter int IAW      = $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [IAW-1:0]      iaddr,
  input  logic [7:0]          idata,
  input  logic                iwe_n,
  input  logic                ird_n,
  output logic [7:0]          odata,
  input  logic [CHANNELS-1:0] drq,
  input  logic                hlda,
  output logic                hrq,
  output logic [CHANNELS-1:0] dack,
  output logic [AW-1:0]       oaddr,
  output logic                ord_n,
  output logic                owe_n,
  output logic                oiord_n,
  output logic                oiowe_n,
  output logic                tc
);

  localparam int CHW     = $clog2(CHANNELS);
  localparam int IDX_EN  = 2 * CHANNELS;
  localparam int IDX_CTL = 2 * CHANNELS + 1;
  localparam int AL_CH   = CHANNELS - 2;

  dma_state_t          state_q;
  logic [CHW-1:0]      cur_q;
  logic [CHW-1:0]      last_q;
  logic [CHANNELS-1:0] enable_q;
  logic [CTL_BITS-1:0] ctrl_q;
  logic [CHANNELS-1:0] tc_flags;
  logic                upd_q;
  logic                byte_ff;

  logic                iwe_q;
  logic                ird_q;
  logic [IAW-1:0]      rd_idx_q;
  logic                cpu_wr_ok;
  logic                tc_clr;

  logic [AW-1:0]       ch_addr [CHANNELS];
  logic [CW+1:0]       ch_cnt  [CHANNELS];
  logic [CHANNELS-1:0] ch_last;
  logic [CHANNELS-1:0] wr_addr_v;
  logic [CHANNELS-1:0] wr_cnt_v;
  logic [CHANNELS-1:0] step_v;
  logic [CHANNELS-1:0] load_v;
  logic                autoload_go;

  logic [CHANNELS-1:0] req;
  logic [CHW-1:0]      win;
  logic                win_ok;

  // One register access per strobe edge: write on iwe_n fall, status clear on ird_n rise
  always_ff @(posedge clk) begin
    if (reset) begin
      iwe_q    <= 1'b1;
      ird_q    <= 1'b1;
      rd_idx_q <= '0;
    end else begin
      iwe_q <= iwe_n;
      ird_q <= ird_n;
      if (!ird_n) rd_idx_q <= iaddr;
    end
  end

  assign cpu_wr_ok = iwe_q && !iwe_n && (state_q == ST_IDLE);
  assign tc_clr    = ird_n && !ird_q && (rd_idx_q == IAW'(IDX_EN));

  // Shared low/high byte pointer for address and count loads
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ff <= 1'b0;
    end else if (cpu_wr_ok && iaddr == IAW'(IDX_CTL)) begin
      byte_ff <= 1'b0;
    end else if (cpu_wr_ok && iaddr < IAW'(IDX_EN)) begin
      byte_ff <= ~byte_ff;
    end
  end

  assign autoload_go = ce && (state_q == ST_XFER) && ctrl_q[CTL_AUTOLOAD] && tc &&
                       (cur_q == CHW'(AL_CH));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign wr_addr_v[g] = cpu_wr_ok && (iaddr == IAW'(2 * g));
    assign wr_cnt_v[g]  = cpu_wr_ok && (iaddr == IAW'(2 * g + 1));
    assign step_v[g]    = ce && (state_q == ST_XFER) && (cur_q == CHW'(g));
    assign load_v[g]    = (g == AL_CH) && autoload_go;

    apogee_dma_channel #(
      .AW (AW),
      .CW (CW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_addr   (wr_addr_v[g]),
      .wr_cnt    (wr_cnt_v[g]),
      .byte_hi   (byte_ff),
      .wdata     (idata),
      .step      (step_v[g]),
      .load      (load_v[g]),
      .load_addr (ch_addr[CHANNELS-1]),
      .load_cnt  (ch_cnt[CHANNELS-1]),
      .addr      (ch_addr[g]),
      .cnt       (ch_cnt[g]),
      .last      (ch_last[g])
    );
  end

  assign req = drq & enable_q;

  // Winner search starts at channel 0, or just after the last serviced one when rotating
  always_comb begin
    int idx;
    idx    = 0;
    win    = '0;
    win_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = ctrl_q[CTL_ROTATE] ? (int'(last_q) + 1 + i) % CHANNELS : i;
      if (!win_ok && req[idx[CHW-1:0]]) begin
        win    = idx[CHW-1:0];
        win_ok = 1'b1;
      end
    end
  end

  // Read mux: status or enable mask while ird_n is low, otherwise zero
  always_comb begin
    odata = 8'h00;
    if (!ird_n) begin
      if (iaddr == IAW'(IDX_EN)) odata = 8'(tc_flags) | {upd_q, 7'b0};
      else if (iaddr == IAW'(IDX_CTL)) odata = 8'(enable_q);
    end
  end

  // Transfer sequencer plus enable/control/flag registers it shares with the CPU port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                         <= ST_IDLE;
      hrq                             <= 1'b0;
      dack                            <= '0;
      tc                              <= 1'b0;
      {ord_n, owe_n, oiord_n, oiowe_n} <= 4'hF;
      oaddr                           <= '0;
      cur_q                           <= '0;
      last_q                          <= CHW'(CHANNELS - 1);
      enable_q                        <= '0;
      ctrl_q                          <= '0;
      tc_flags                        <= '0;
      upd_q                           <= 1'b0;
    end else begin
      if (tc_clr) tc_flags <= '0;
      if (cpu_wr_ok && iaddr == IAW'(IDX_EN)) enable_q <= idata[CHANNELS-1:0];
      if (cpu_wr_ok && iaddr == IAW'(IDX_CTL)) begin
        ctrl_q <= idata[CTL_BITS-1:0];
        if (!idata[CTL_AUTOLOAD]) upd_q <= 1'b0;
      end
      if (ce) begin
        case (state_q)
          ST_IDLE: begin
            if (|req) begin
              state_q <= ST_REQ;
              hrq     <= 1'b1;
            end
          end
          ST_REQ: begin
            if (!(|req)) begin
              state_q <= ST_IDLE;
              hrq     <= 1'b0;
            end else if (hlda && win_ok) begin
              state_q <= ST_ADDR;
              cur_q   <= win;
              dack    <= CHANNELS'(1) << win;
              oaddr   <= ch_addr[win];
              tc      <= ch_last[win];
            end
          end
          ST_ADDR: begin
            state_q                         <= ST_XFER;
            {ord_n, owe_n, oiord_n, oiowe_n} <= strobe_pattern(xfer_type_t'(ch_cnt[cur_q][CW+1:CW]));
          end
          ST_XFER: begin
            state_q                         <= ST_DONE;
            {ord_n, owe_n, oiord_n, oiowe_n} <= 4'hF;
            last_q                          <= cur_q;
            if (tc) begin
              tc_flags[cur_q] <= 1'b1;
              if (ctrl_q[CTL_AUTOLOAD] && cur_q == CHW'(AL_CH)) upd_q <= 1'b1;
              else if (ctrl_q[CTL_TC_STOP]) enable_q[cur_q] <= 1'b0;
            end
          end
          ST_DONE: begin
            if (ctrl_q[CTL_BURST] && req[cur_q] && !tc) begin
              state_q <= ST_ADDR;
              oaddr   <= ch_addr[cur_q];
              tc      <= ch_last[cur_q];
            end else begin
              dack <= '0;
              tc   <= 1'b0;
              if (|req) begin
                state_q <= ST_REQ;
              end else begin
                state_q <= ST_IDLE;
                hrq     <= 1'b0;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apogee_dma.sv
// tb/tb_apogee_dma.sv - scoreboard bench for apogee_dma
module tb_apogee_dma;

  localparam int CH = 4;
  localparam int IDX_ST = 8;
  localparam int IDX_CT = 9;
  localparam logic [3:0] RD = 4'b0110;  // {ord_n, owe_n, oiord_n, oiowe_n}
  localparam logic [3:0] WR = 4'b1001;

  logic          clk, reset, ce;
  logic [3:0]    iaddr;
  logic [7:0]    idata, odata;
  logic          iwe_n, ird_n;
  logic [CH-1:0] drq, dack;
  logic          hlda, hrq, tc;
  logic [15:0]   oaddr;
  logic          ord_n, owe_n, oiord_n, oiowe_n;

  int n_chk = 0;
  int n_bad = 0;
  int hrq_low = 0;

  typedef struct packed {
    logic [3:0]  dack;
    logic [15:0] addr;
    logic        tc;
    logic [3:0]  strb;
    logic [3:0]  drop;
    logic [7:0]  gap;
  } exp_t;

  exp_t sb[$];

  apogee_dma dut (
    .clk(clk), .reset(reset), .ce(ce), .iaddr(iaddr), .idata(idata),
    .iwe_n(iwe_n), .ird_n(ird_n), .odata(odata), .drq(drq), .hlda(hlda),
    .hrq(hrq), .dack(dack), .oaddr(oaddr), .ord_n(ord_n), .owe_n(owe_n),
    .oiord_n(oiord_n), .oiowe_n(oiowe_n), .tc(tc)
  );

  assign hlda = hrq;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clk);
      #1 ce = ~ce;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    drq = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic cpu_wr(input int idx, input logic [7:0] d);
    @(posedge clk);
    #1 iaddr = 4'(idx); idata = d; iwe_n = 1'b0;
    @(posedge clk);
    #1 iwe_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic prog16(input int idx, input logic [15:0] v);
    cpu_wr(idx, v[7:0]);
    cpu_wr(idx, v[15:8]);
  endtask

  task automatic cpu_rd(input int idx, output logic [7:0] d);
    @(posedge clk);
    #1 iaddr = 4'(idx); ird_n = 1'b0;
    @(negedge clk);
    d = odata;
    @(posedge clk);
    #1 ird_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_x(input int ch, input logic [15:0] a, input logic t,
                        input logic [3:0] st, input logic [3:0] drop, input int gap);
    exp_t e;
    e.dack = 4'(1 << ch);
    e.addr = a;
    e.tc   = t;
    e.strb = st;
    e.drop = drop;
    e.gap  = 8'(gap);
    sb.push_back(e);
  endtask

  // Watch strobes clock by clock, pop one expectation per transfer, stop once quiet
  task automatic run_sb(input int budget);
    int n, start_cyc, last_start, idle_cnt;
    logic prev_act, seen;
    logic [3:0] s;
    exp_t e;
    n = 0; start_cyc = 0; last_start = 0; idle_cnt = 0;
    prev_act = 1'b0; seen = 1'b0; hrq_low = 0;
    while (n < budget && idle_cnt < 20) begin
      @(negedge clk);
      n++;
      s = {ord_n, owe_n, oiord_n, oiowe_n};
      if (s != 4'hF && !prev_act) begin
        start_cyc = n;
        if (sb.size() == 0) begin
          chk("extra_xfer", 32'(oaddr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("dack", 32'(dack), 32'(e.dack));
          chk("oaddr", 32'(oaddr), 32'(e.addr));
          chk("tc", 32'(tc), 32'(e.tc));
          chk("strobes", 32'(s), 32'(e.strb));
          if (seen && e.gap != 0) chk("xfer_gap", 32'(n - last_start), 32'(e.gap));
          drq = drq & ~e.drop;
          seen = 1'b1;
          last_start = n;
        end
      end
      if (s == 4'hF && prev_act) chk("strobe_width", 32'(n - start_cyc), 32'd2);
      if (seen && sb.size() != 0 && !hrq) hrq_low++;
      prev_act = (s != 4'hF);
      idle_cnt = (sb.size() == 0 && !hrq && !prev_act) ? idle_cnt + 1 : 0;
    end
    if (idle_cnt < 20) chk("timeout", 32'(n), 32'(budget + 1));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic found;
    reset = 1'b1; iaddr = '0; idata = '0; iwe_n = 1'b1; ird_n = 1'b1; drq = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_hrq", 32'(hrq), 0);
    chk("rst_dack", 32'(dack), 0);
    chk("rst_tc", 32'(tc), 0);
    chk("rst_strobes", 32'({ord_n, owe_n, oiord_n, oiowe_n}), 32'hF);
    chk("rst_oaddr", 32'(oaddr), 0);
    chk("rst_odata", 32'(odata), 0);
    cpu_rd(IDX_ST, d);
    chk("rst_status", 32'(d), 0);

    // 80 reads on channel 2
    prog16(4, 16'h7600);
    prog16(5, 16'h804F);
    cpu_wr(IDX_ST, 8'h04);
    for (int i = 0; i < 80; i++)
      push_x(2, 16'h7600 + 16'(i), i == 79, RD, (i == 79) ? 4'b0100 : 4'b0000, (i == 0) ? 0 : 8);
    drq = 4'b0100;
    run_sb(2000);
    cpu_rd(IDX_ST, d);
    chk("status_tc2", 32'(d), 32'h04);
    cpu_rd(IDX_ST, d);
    chk("status_cleared", 32'(d), 32'h00);

    // Fixed priority with tc_stop
    do_reset();
    prog16(0, 16'h0100); prog16(1, 16'h8001);
    prog16(2, 16'h0200); prog16(3, 16'h8001);
    cpu_wr(IDX_ST, 8'h03);
    cpu_wr(IDX_CT, 8'h02);
    push_x(0, 16'h0100, 1'b0, RD, 4'b0, 0);
    push_x(0, 16'h0101, 1'b1, RD, 4'b0, 8);
    push_x(1, 16'h0200, 1'b0, RD, 4'b0, 8);
    push_x(1, 16'h0201, 1'b1, RD, 4'b0, 8);
    drq = 4'b0011;
    run_sb(500);

    // Rotating priority with tc_stop
    do_reset();
    prog16(0, 16'h0100); prog16(1, 16'h8001);
    prog16(2, 16'h0200); prog16(3, 16'h8001);
    cpu_wr(IDX_ST, 8'h03);
    cpu_wr(IDX_CT, 8'h03);
    push_x(0, 16'h0100, 1'b0, RD, 4'b0, 0);
    push_x(1, 16'h0200, 1'b0, RD, 4'b0, 8);
    push_x(0, 16'h0101, 1'b1, RD, 4'b0, 8);
    push_x(1, 16'h0201, 1'b1, RD, 4'b0, 8);
    drq = 4'b0011;
    run_sb(500);

    // Autoload of channel 2 from channel 3
    do_reset();
    prog16(6, 16'h1000); prog16(7, 16'h4001);
    prog16(4, 16'h2000); prog16(5, 16'h4000);
    cpu_wr(IDX_ST, 8'h04);
    cpu_wr(IDX_CT, 8'h04);
    push_x(2, 16'h2000, 1'b1, WR, 4'b0, 0);
    push_x(2, 16'h1000, 1'b0, WR, 4'b0, 8);
    push_x(2, 16'h1001, 1'b1, WR, 4'b0100, 8);
    drq = 4'b0100;
    run_sb(500);
    cpu_rd(IDX_ST, d);
    chk("autoload_status", 32'(d), 32'h84);

    // TC stop on channel 1 with drq left high
    do_reset();
    prog16(2, 16'h0300); prog16(3, 16'h8002);
    cpu_wr(IDX_ST, 8'h02);
    cpu_wr(IDX_CT, 8'h02);
    push_x(1, 16'h0300, 1'b0, RD, 4'b0, 0);
    push_x(1, 16'h0301, 1'b0, RD, 4'b0, 8);
    push_x(1, 16'h0302, 1'b1, RD, 4'b0, 8);
    drq = 4'b0010;
    run_sb(500);
    chk("tcstop_hrq", 32'(hrq), 0);
    cpu_rd(IDX_CT, d);
    chk("tcstop_enable", 32'(d), 32'h00);

    // Burst on channel 0
    do_reset();
    prog16(0, 16'h0400); prog16(1, 16'h8003);
    cpu_wr(IDX_ST, 8'h01);
    cpu_wr(IDX_CT, 8'h08);
    push_x(0, 16'h0400, 1'b0, RD, 4'b0, 0);
    push_x(0, 16'h0401, 1'b0, RD, 4'b0, 6);
    push_x(0, 16'h0402, 1'b0, RD, 4'b0, 6);
    push_x(0, 16'h0403, 1'b1, RD, 4'b0001, 6);
    drq = 4'b0001;
    run_sb(500);
    chk("burst_hrq_held", 32'(hrq_low), 0);

    // Reset during XFER, then reprogram from a cleared byte pointer
    do_reset();
    prog16(0, 16'h0500); prog16(1, 16'h8005);
    cpu_wr(IDX_ST, 8'h01);
    cpu_wr(0, 8'h11);
    drq = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!ord_n) found = 1'b1;
    end
    chk("mid_xfer_seen", 32'(found), 1);
    reset = 1'b1;
    drq = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_strobes", 32'({ord_n, owe_n, oiord_n, oiowe_n}), 32'hF);
    chk("midrst_hrq", 32'(hrq), 0);
    chk("midrst_dack", 32'(dack), 0);
    reset = 1'b0;
    prog16(2, 16'h0600); prog16(3, 16'h8000);
    cpu_wr(IDX_ST, 8'h02);
    push_x(1, 16'h0600, 1'b1, RD, 4'b0010, 0);
    drq = 4'b0010;
    run_sb(500);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
